// File: rtl/tcam_reg_frame_assembler.sv
// Register-bus receive stage for TCAM command frames: collects 16-bit words,
// decodes the 2-bit-per-bit TCAM encoding and hands one command downstream.
module tcam_reg_frame_assembler #(
  parameter int LOOK_UP_DATA_WIDTH = 144,
  parameter int ACTION_WIDTH       = 24,
  parameter int REG_ADDR_BUS_WIDTH = 8,
  parameter int REG_DATA_BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES     = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_reg_bus_we,
  input  logic [REG_ADDR_BUS_WIDTH-1:0] i_reg_bus_we_addr,
  input  logic [REG_DATA_BUS_WIDTH-1:0] i_reg_bus_we_din,
  input  logic                          i_reg_bus_we_din_v,
  output logic                          o_tcam_busy,
  output logic                          o_cmd_valid,
  input  logic                          i_cmd_ready,
  output logic [1:0]                    o_cmd_type,
  output logic [LOOK_UP_DATA_WIDTH-1:0] o_key_data,
  output logic [LOOK_UP_DATA_WIDTH-1:0] o_key_mask,
  output logic [ACTION_WIDTH-1:0]       o_action,
  output logic                          o_frame_err,
  output logic [2:0]                    o_err_code
);

  localparam int FRAME_W = 2*LOOK_UP_DATA_WIDTH + 2*ACTION_WIDTH;
  localparam int WORDS   = (FRAME_W + REG_DATA_BUS_WIDTH - 1) / REG_DATA_BUS_WIDTH;
  localparam int BUF_W   = WORDS * REG_DATA_BUS_WIDTH;
  localparam int CNT_W   = $clog2(WORDS + 1);
  localparam int GAP_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DECODE, S_OUTPUT} state_t;

  typedef enum logic [2:0] {
    E_NONE          = 3'd0,
    E_BAD_TYPE      = 3'd1,
    E_TYPE_MISMATCH = 3'd2,
    E_TIMEOUT       = 3'd3,
    E_ACTION        = 3'd4,
    E_BUSY          = 3'd5
  } err_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [1:0]       frame_type, frame_type_nxt;
  logic [BUF_W-1:0] frame_buf;
  logic             shift_en;
  logic             load_cmd;
  logic             err_fire;
  err_t             err_code_nxt;

  logic       word_acc;
  logic [1:0] word_type;

  assign word_acc  = i_reg_bus_we & i_reg_bus_we_din_v &
                     (i_reg_bus_we_addr[REG_ADDR_BUS_WIDTH-3:0] == '0);
  assign word_type = i_reg_bus_we_addr[REG_ADDR_BUS_WIDTH-1 -: 2];

  // First word lands at the top of the buffer; a short last word leaves its
  // unused low bits below the frame slice.
  logic [FRAME_W-1:0] frame;
  assign frame = frame_buf[BUF_W-1 -: FRAME_W];

  logic [LOOK_UP_DATA_WIDTH-1:0] dec_data, dec_mask;
  logic [ACTION_WIDTH-1:0]       dec_action;
  logic                          action_bad;

  always_comb begin
    dec_data   = '0;
    dec_mask   = '0;
    dec_action = '0;
    action_bad = 1'b0;
    for (int i = 0; i < LOOK_UP_DATA_WIDTH; i++) begin
      dec_data[i] = frame[2*ACTION_WIDTH + 2*i];
      dec_mask[i] = frame[2*ACTION_WIDTH + 2*i + 1];
    end
    for (int j = 0; j < ACTION_WIDTH; j++) begin
      dec_action[j] = frame[2*j];
      action_bad    = action_bad | frame[2*j + 1];
    end
  end

  always_comb begin
    state_nxt      = state;
    word_cnt_nxt   = word_cnt;
    gap_cnt_nxt    = gap_cnt;
    frame_type_nxt = frame_type;
    shift_en       = 1'b0;
    load_cmd       = 1'b0;
    err_fire       = 1'b0;
    err_code_nxt   = E_NONE;

    case (state)
      S_IDLE: begin
        if (word_acc) begin
          if (word_type == 2'b11) begin
            err_fire     = 1'b1;
            err_code_nxt = E_BAD_TYPE;
          end else begin
            frame_type_nxt = word_type;
            shift_en       = 1'b1;
            word_cnt_nxt   = CNT_W'(1);
            gap_cnt_nxt    = '0;
            state_nxt      = (WORDS == 1) ? S_DECODE : S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        if (word_acc) begin
          if (word_type != frame_type) begin
            err_fire     = 1'b1;
            err_code_nxt = E_TYPE_MISMATCH;
            word_cnt_nxt = '0;
            gap_cnt_nxt  = '0;
            state_nxt    = S_IDLE;
          end else begin
            shift_en     = 1'b1;
            gap_cnt_nxt  = '0;
            word_cnt_nxt = word_cnt + CNT_W'(1);
            if (word_cnt == CNT_W'(WORDS - 1)) state_nxt = S_DECODE;
          end
        end else if (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1)) begin
          // An arriving word always beats the timeout in the same cycle.
          err_fire     = 1'b1;
          err_code_nxt = E_TIMEOUT;
          word_cnt_nxt = '0;
          gap_cnt_nxt  = '0;
          state_nxt    = S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end

      S_DECODE: begin
        load_cmd     = 1'b1;
        word_cnt_nxt = '0;
        if (word_acc) begin
          err_fire     = 1'b1;
          err_code_nxt = E_BUSY;
        end
        // A bad action kills the whole frame, so it outranks a dropped word.
        if (action_bad) begin
          err_fire     = 1'b1;
          err_code_nxt = E_ACTION;
          state_nxt    = S_IDLE;
        end else begin
          state_nxt = S_OUTPUT;
        end
      end

      S_OUTPUT: begin
        if (word_acc) begin
          err_fire     = 1'b1;
          err_code_nxt = E_BUSY;
        end
        if (i_cmd_ready) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      frame_type  <= 2'b00;
      o_cmd_type  <= 2'b00;
      o_key_data  <= '0;
      o_key_mask  <= '0;
      o_action    <= '0;
      o_frame_err <= 1'b0;
      o_err_code  <= 3'd0;
    end else begin
      state       <= state_nxt;
      word_cnt    <= word_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      frame_type  <= frame_type_nxt;
      o_frame_err <= err_fire;
      if (err_fire) o_err_code <= err_code_nxt;
      if (load_cmd) begin
        o_cmd_type <= frame_type;
        o_key_data <= dec_data;
        o_key_mask <= dec_mask;
        o_action   <= dec_action;
      end
    end
  end

  // NOTE: the frame buffer has no reset; the word count alone decides when its
  // contents are meaningful, and a full frame overwrites every bit.
  always_ff @(posedge clk) begin
    if (shift_en)
      frame_buf <= (frame_buf << REG_DATA_BUS_WIDTH) | BUF_W'(i_reg_bus_we_din);
  end

  assign o_tcam_busy = (state == S_DECODE) || (state == S_OUTPUT);
  assign o_cmd_valid = (state == S_OUTPUT);

endmodule

// File: tb/tb_tcam_reg_frame_assembler.sv
// Self-checking bench: a queue-based frame model predicts every output each
// cycle; directed scenarios add literal expectations on top.
module tb_tcam_reg_frame_assembler;

  localparam int LW      = 144;
  localparam int AW      = 24;
  localparam int FRAME_W = 2*LW + 2*AW;
  localparam int WORDS   = 21;
  localparam int TO      = 64;

  localparam logic [LW-1:0] D1 = 144'h123456789ABCDEF0123456789ABCDEF01234;
  localparam logic [AW-1:0] A1 = 24'h654321;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_reg_bus_we = 1'b0;
  logic [7:0]    i_reg_bus_we_addr = '0;
  logic [15:0]   i_reg_bus_we_din = '0;
  logic          i_reg_bus_we_din_v = 1'b0;
  logic          i_cmd_ready = 1'b1;
  logic          o_tcam_busy, o_cmd_valid, o_frame_err;
  logic [1:0]    o_cmd_type;
  logic [LW-1:0] o_key_data, o_key_mask;
  logic [AW-1:0] o_action;
  logic [2:0]    o_err_code;

  tcam_reg_frame_assembler dut (
    .clk(clk), .rst(rst),
    .i_reg_bus_we(i_reg_bus_we), .i_reg_bus_we_addr(i_reg_bus_we_addr),
    .i_reg_bus_we_din(i_reg_bus_we_din), .i_reg_bus_we_din_v(i_reg_bus_we_din_v),
    .o_tcam_busy(o_tcam_busy), .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_type(o_cmd_type), .o_key_data(o_key_data), .o_key_mask(o_key_mask),
    .o_action(o_action), .o_frame_err(o_frame_err), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned   m_phase = 0;   // 0 no frame pending, 1 decode cycle, 2 offered
  bit            m_collecting = 1'b0;
  logic [1:0]    m_type = '0;
  int            m_gap = 0;
  logic [15:0]   m_words[$];
  logic [1:0]    e_type = '0;
  logic [LW-1:0] e_data = '0, e_mask = '0;
  logic [AW-1:0] e_action = '0;
  logic          e_err = 1'b0;
  logic [2:0]    e_code = '0;

  always @(posedge clk) begin
    bit acc, bad;
    int err;
    logic [FRAME_W-1:0] fr;
    acc = i_reg_bus_we && i_reg_bus_we_din_v && (i_reg_bus_we_addr[5:0] == 6'd0);
    err = 0;
    if (rst) begin
      m_phase = 0; m_collecting = 0; m_words.delete(); m_gap = 0;
      e_type = '0; e_data = '0; e_mask = '0; e_action = '0; e_err = 0; e_code = '0;
    end else begin
      if (m_phase == 1) begin
        fr = '0;
        for (int k = 0; k < WORDS; k++) fr[(WORDS-1-k)*16 +: 16] = m_words[k];
        bad = 0;
        for (int i = 0; i < LW; i++) begin
          e_data[i] = fr[2*AW + 2*i];
          e_mask[i] = fr[2*AW + 2*i + 1];
        end
        for (int j = 0; j < AW; j++) begin
          e_action[j] = fr[2*j];
          if (fr[2*j+1]) bad = 1;
        end
        e_type = m_type;
        m_words.delete();
        if (bad) begin err = 4; m_phase = 0; end
        else m_phase = 2;
        if (acc && err == 0) err = 5;
      end else if (m_phase == 2) begin
        if (acc) err = 5;
        if (i_cmd_ready) m_phase = 0;
      end else if (m_collecting) begin
        if (acc) begin
          if (i_reg_bus_we_addr[7:6] != m_type) begin
            err = 2; m_collecting = 0; m_words.delete();
          end else begin
            m_words.push_back(i_reg_bus_we_din);
            m_gap = 0;
            if (m_words.size() == WORDS) begin m_collecting = 0; m_phase = 1; end
          end
        end else begin
          m_gap++;
          if (m_gap == TO) begin err = 3; m_collecting = 0; m_words.delete(); end
        end
      end else if (acc) begin
        if (i_reg_bus_we_addr[7:6] == 2'b11) err = 1;
        else begin
          m_words.delete();
          m_words.push_back(i_reg_bus_we_din);
          m_type = i_reg_bus_we_addr[7:6];
          m_collecting = 1;
          m_gap = 0;
        end
      end
      e_err = (err != 0);
      if (err != 0) e_code = 3'(err);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      o_tcam_busy, m_phase != 0);
      check("valid",     o_cmd_valid, m_phase == 2);
      check("frame_err", o_frame_err, e_err);
      check("err_code",  o_err_code,  e_code);
      check("cmd_type",  o_cmd_type,  e_type);
      check("key_data",  o_key_data,  e_data);
      check("key_mask",  o_key_mask,  e_mask);
      check("action",    o_action,    e_action);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [FRAME_W-1:0] encode(input logic [LW-1:0] d, input logic [LW-1:0] m,
                                                input logic [AW-1:0] a, input int bad_j);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int i = 0; i < LW; i++) f[2*AW + 2*i +: 2] = {m[i], d[i]};
    for (int j = 0; j < AW; j++) f[2*j +: 2] = {1'b0, a[j]};
    if (bad_j >= 0) f[2*bad_j + 1] = 1'b1;
    return f;
  endfunction

  function automatic logic [LW-1:0] rand_key();
    logic [159:0] r;
    for (int k = 0; k < 5; k++) r[k*32 +: 32] = $urandom;
    return r[LW-1:0];
  endfunction

  task automatic step();
    @(posedge clk); #1;
    if (rand_ready) i_cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic drive_word(input logic [1:0] typ, input logic [15:0] w);
    i_reg_bus_we = 1'b1; i_reg_bus_we_din_v = 1'b1;
    i_reg_bus_we_addr = {typ, 6'd0}; i_reg_bus_we_din = w;
    step();
    i_reg_bus_we = 1'b0; i_reg_bus_we_din_v = 1'b0;
  endtask

  // Strobe that must be ignored: din_v low or a nonzero low address.
  task automatic drive_noise();
    i_reg_bus_we = 1'b1;
    i_reg_bus_we_din_v = 1'($urandom_range(0, 1));
    i_reg_bus_we_addr = {2'($urandom_range(0, 3)), 6'($urandom_range(1, 63))};
    if (!i_reg_bus_we_din_v) i_reg_bus_we_addr[5:0] = 6'($urandom_range(0, 63));
    i_reg_bus_we_din = 16'($urandom);
    step();
    i_reg_bus_we = 1'b0; i_reg_bus_we_din_v = 1'b0;
  endtask

  task automatic send_words(input logic [1:0] typ, input logic [FRAME_W-1:0] f,
                            input int first, input int last);
    for (int k = first; k <= last; k++) drive_word(typ, f[(WORDS-1-k)*16 +: 16]);
  endtask

  // Called right after the final word's edge N; consumes at N+2 with ready=1.
  task automatic expect_delivery(input string tag, input logic [1:0] typ,
                                 input logic [LW-1:0] d, input logic [LW-1:0] m,
                                 input logic [AW-1:0] a);
    @(negedge clk);
    check({tag, "_busy_n1"},  o_tcam_busy, 1'b1);
    check({tag, "_valid_n1"}, o_cmd_valid, 1'b0);
    @(posedge clk); @(negedge clk);
    check({tag, "_valid_n2"}, o_cmd_valid, 1'b1);
    check({tag, "_type"},     o_cmd_type,  typ);
    check({tag, "_data"},     o_key_data,  d);
    check({tag, "_mask"},     o_key_mask,  m);
    check({tag, "_action"},   o_action,    a);
    check({tag, "_no_err"},   o_frame_err, 1'b0);
    check({tag, "_model_data"}, e_data, d);
    @(posedge clk); #1;
  endtask

  initial begin : main
    logic [FRAME_W-1:0] f;
    logic [LW-1:0] d, m;
    logic [AW-1:0] a;
    logic [1:0] typ;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", o_tcam_busy, 1'b0);
    check("rst_valid", o_cmd_valid, 1'b0);
    check("rst_data", o_key_data, '0);
    check("rst_code", o_err_code, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    // Plain write frame.
    f = encode(D1, '0, A1, -1);
    send_words(2'b00, f, 0, WORDS-1);
    expect_delivery("write", 2'b00, D1, '0, A1);

    // Don't-care on the low key byte, modify type.
    f = encode(D1, 144'hFF, A1, -1);
    send_words(2'b01, f, 0, WORDS-1);
    expect_delivery("dontcare", 2'b01, D1, 144'hFF, A1);
    check("dontcare_model_mask", e_mask, 144'hFF);

    // Backpressure with a stray word while the command is pending.
    i_cmd_ready = 1'b0;
    f = encode(D1, '0, A1, -1);
    send_words(2'b00, f, 0, WORDS-1);
    idle_cycles(2);
    drive_word(2'b00, 16'hBEEF);
    @(negedge clk);
    check("bp_err_pulse", o_frame_err, 1'b1);
    check("bp_err_code", o_err_code, 3'd5);
    check("bp_valid", o_cmd_valid, 1'b1);
    check("bp_data_held", o_key_data, D1);
    @(posedge clk); #1;
    idle_cycles(6);
    i_cmd_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_busy_released", o_tcam_busy, 1'b0);
    check("bp_valid_released", o_cmd_valid, 1'b0);
    @(posedge clk); #1;

    // Type mismatch on word 5, then a clean delete frame.
    f = encode(D1, '0, A1, -1);
    send_words(2'b00, f, 0, 3);
    drive_word(2'b01, f[(WORDS-5)*16 +: 16]);
    @(negedge clk);
    check("mismatch_err", o_frame_err, 1'b1);
    check("mismatch_code", o_err_code, 3'd2);
    @(posedge clk); #1;
    idle_cycles(2);
    d = 144'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F_C3C3;
    f = encode(d, 144'h3, 24'hABCDEF, -1);
    send_words(2'b10, f, 0, WORDS-1);
    expect_delivery("delete", 2'b10, d, 144'h3, 24'hABCDEF);

    // Idle-gap timeout after 10 words.
    f = encode(D1, '0, A1, -1);
    send_words(2'b00, f, 0, 9);
    idle_cycles(TO-1);
    @(negedge clk);
    check("timeout_not_yet", o_frame_err, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("timeout_err", o_frame_err, 1'b1);
    check("timeout_code", o_err_code, 3'd3);
    check("timeout_busy", o_tcam_busy, 1'b0);
    @(posedge clk); #1;

    // A word on the would-be timeout edge keeps the frame alive.
    send_words(2'b00, f, 0, 9);
    idle_cycles(TO-1);
    send_words(2'b00, f, 10, WORDS-1);
    expect_delivery("gap_edge", 2'b00, D1, '0, A1);

    // Bad action encoding.
    f = encode(D1, '0, A1, 7);
    send_words(2'b00, f, 0, WORDS-1);
    @(negedge clk);
    check("action_busy", o_tcam_busy, 1'b1);
    @(posedge clk); @(negedge clk);
    check("action_err", o_frame_err, 1'b1);
    check("action_code", o_err_code, 3'd4);
    check("action_no_valid", o_cmd_valid, 1'b0);
    @(posedge clk); #1;

    // Reserved type on a first word.
    drive_word(2'b11, 16'h1111);
    @(negedge clk);
    check("type11_err", o_frame_err, 1'b1);
    check("type11_code", o_err_code, 3'd1);
    @(posedge clk); #1;

    // Reset in place of word 12.
    f = encode(D1, '0, A1, -1);
    send_words(2'b00, f, 0, 10);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_busy", o_tcam_busy, 1'b0);
    check("midrst_code", o_err_code, 3'd0);
    check("midrst_action", o_action, '0);
    check("midrst_type", o_cmd_type, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    send_words(2'b01, f, 0, WORDS-1);
    expect_delivery("post_rst", 2'b01, D1, '0, A1);

    // Randomized frames with noise, gaps, errors and random ready.
    rand_ready = 1'b1;
    for (int fr_i = 0; fr_i < 40; fr_i++) begin
      int bad_j, mm_idx, to_idx;
      typ = 2'($urandom_range(0, 2));
      d = rand_key(); m = rand_key() & rand_key(); a = 24'($urandom);
      bad_j  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, AW-1)) : -1;
      mm_idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, WORDS-1)) : -1;
      to_idx = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, WORDS-1)) : -1;
      f = encode(d, m, a, bad_j);
      for (int k = 0; k < WORDS; k++) begin
        if (k == to_idx) idle_cycles(TO);
        else begin
          int gap;
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) begin
            if ($urandom_range(0, 3) == 0) drive_noise(); else step();
          end
        end
        drive_word((k == mm_idx) ? (typ ^ 2'b01) : typ, f[(WORDS-1-k)*16 +: 16]);
      end
      for (int c = 0; c < 400 && (m_phase != 0 || m_collecting); c++) begin
        if (m_phase != 0 && $urandom_range(0, 5) == 0)
          drive_word(2'($urandom_range(0, 3)), 16'($urandom));
        else step();
      end
      check("rand_drain", (m_phase != 0) || m_collecting, 1'b0);
      idle_cycles(int'($urandom_range(1, 3)));
    end

    rand_ready = 1'b0;
    i_cmd_ready = 1'b1;
    idle_cycles(3);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
